sipo_deserializer: RTL and testbench

- Downstream receive stage for the serial stream produced by the PISO register.
- Collects WIDTH qualified serial bits and assembles them into a parallel word.
- Presents each completed word on a valid/ready output port backed by a one-word holding register.
- Flags overrun when a word completes while the previous word is still unconsumed.

---
 rtl/serial_pkg.sv | 21 ++
 rtl/sipo_deserializer_if.sv | 30 +++
 rtl/sipo_deserializer.sv | 74 +++++++
 tb/tb_sipo_deserializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (PISO transmitter and SIPO receiver).
package serial_pkg;

    // Default word width of the serial link.
    localparam int SER_WIDTH = 8;

    // Bit-order encodings for the MSB_FIRST parameter.
    localparam bit ORDER_LSB_FIRST = 1'b0;
    localparam bit ORDER_MSB_FIRST = 1'b1;

    typedef enum logic {
        BIT_ORDER_LSB = 1'b0,
        BIT_ORDER_MSB = 1'b1
    } bit_order_e;

    // Width of a counter that indexes bits 0..w-1. Never returns less than 1 bit.
    function automatic int cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial-in / parallel-out bus: serial input side plus valid/ready word output.
interface sipo_deserializer_if
    import serial_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH
) ();
    localparam int CW = cnt_w(WIDTH);

    logic             sin;
    logic             sin_valid;
    logic             sin_sync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
    logic             overrun_clr;

    // Producer/consumer side: drives serial bits and consumes words.
    modport master (
        output sin, sin_valid, sin_sync, dout_ready, overrun_clr,
        input  dout, dout_valid, bit_cnt, overrun
    );

    // Deserializer side.
    modport slave (
        input  sin, sin_valid, sin_sync, dout_ready, overrun_clr,
        output dout, dout_valid, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_deserializer.sv
// Collects WIDTH serial bits into a word and holds it in a one-word
// valid/ready output register; flags a sticky overrun when a word completes
// while the held word is still unconsumed.
module sipo_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input logic                clk,
    input logic                reset,
    sipo_deserializer_if.slave bus
);
    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;

    logic             w_accept;
    logic             w_complete;
    logic             w_xfer;
    logic             w_drop;
    logic [WIDTH-1:0] w_cand;

    // Sync strobe overrides a qualified bit in the same cycle.
    assign w_accept   = bus.sin_valid & ~bus.sin_sync;
    assign w_complete = w_accept && (r_bit_cnt == CW'(WIDTH - 1));
    // Candidate includes the current bit so the word is available on the
    // completing edge without an extra stage.
    assign w_cand     = MSB_FIRST ? {r_sr[WIDTH-2:0], bus.sin}
                                  : {bus.sin, r_sr[WIDTH-1:1]};
    assign w_xfer     = w_complete && (!r_dout_valid || bus.dout_ready);
    assign w_drop     = w_complete && r_dout_valid && !bus.dout_ready;

    // Shift register and bit counter; sync or reset discard the partial word.
    always_ff @(posedge clk) begin
        if (reset || bus.sin_sync) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_sr      <= w_cand;
            r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CW'(1);
        end
    end

    // Output holding register and sticky overrun; an overrun event beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_dout       <= w_cand;
                r_dout_valid <= 1'b1;
            end else if (r_dout_valid && bus.dout_ready) begin
                r_dout_valid <= 1'b0;
            end
            if (w_drop)
                r_overrun <= 1'b1;
            else if (bus.overrun_clr)
                r_overrun <= 1'b0;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.bit_cnt    = r_bit_cnt;
    assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: two deserializers (MSB-first and LSB-first) share one
// stimulus stream; a queue-based word model predicts words and flags.
module tb_sipo_deserializer;
    import serial_pkg::*;

    localparam int W  = 8;
    localparam int CW = cnt_w(W);

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sipo_deserializer_if #(.WIDTH(W)) ifm ();
    sipo_deserializer_if #(.WIDTH(W)) ifl ();

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .bus(ifm.slave)
    );
    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .bus(ifl.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the partial word in arrival order, plus the
    // word-level state of the output holding register.
    bit         bitq[$];
    logic [W-1:0] qm[$];
    logic [W-1:0] ql[$];
    bit         m_full = 1'b0;
    bit         m_ovr  = 1'b0;
    logic [W-1:0] m_dm = '0;
    logic [W-1:0] m_dl = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit s, input bit v, input bit sy, input bit rdy, input bit clr);
        ifm.sin = s;  ifm.sin_valid = v;  ifm.sin_sync = sy;  ifm.dout_ready = rdy;  ifm.overrun_clr = clr;
        ifl.sin = s;  ifl.sin_valid = v;  ifl.sin_sync = sy;  ifl.dout_ready = rdy;  ifl.overrun_clr = clr;
    endtask

    task automatic check_state();
        chk("valid_m",  32'(ifm.dout_valid), 32'(m_full));
        chk("valid_l",  32'(ifl.dout_valid), 32'(m_full));
        chk("ovr_m",    32'(ifm.overrun),    32'(m_ovr));
        chk("ovr_l",    32'(ifl.overrun),    32'(m_ovr));
        chk("bitcnt_m", 32'(ifm.bit_cnt),    32'(bitq.size()));
        chk("bitcnt_l", 32'(ifl.bit_cnt),    32'(bitq.size()));
        chk("dout_m",   32'(ifm.dout),       32'(m_dm));
        chk("dout_l",   32'(ifl.dout),       32'(m_dl));
    endtask

    // One clock: apply inputs, predict the edge, then compare after it.
    task automatic cyc(input bit s, input bit v, input bit sy, input bit rdy, input bit clr);
        bit           done = 1'b0;
        bit           ovr_evt;
        logic [W-1:0] wm = '0;
        logic [W-1:0] wl = '0;
        drive(s, v, sy, rdy, clr);
        if (sy) begin
            bitq.delete();
        end else if (v) begin
            bitq.push_back(s);
            if (bitq.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = bitq[i];
                    wl[i]     = bitq[i];
                end
                bitq.delete();
                done = 1'b1;
            end
        end
        ovr_evt = done && m_full && !rdy;
        if (done && !ovr_evt) begin
            m_full = 1'b1;
            m_dm = wm;
            m_dl = wl;
            qm.push_back(wm);
            ql.push_back(wl);
        end else if (!done && m_full && rdy) begin
            m_full = 1'b0;
        end
        if (ovr_evt)  m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset(input bit s, input bit v);
        reset = 1'b1;
        drive(s, v, 1'b0, 1'b1, 1'b0);
        bitq.delete();
        qm.delete();
        ql.delete();
        m_full = 1'b0;
        m_ovr  = 1'b0;
        m_dm   = '0;
        m_dl   = '0;
        @(posedge clk);
        #1;
        check_state();
        reset = 1'b0;
    endtask

    // Sends bits w[W-1] first (PISO shift order), optionally with random gaps.
    task automatic send_word(input logic [W-1:0] w, input bit rdy, input bit gaps);
        logic [W-1:0] sh;
        sh = w;
        for (int i = 0; i < W; i++) begin
            if (gaps)
                while ($urandom_range(0, 2) == 0) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, rdy, 1'b0);
            cyc(sh[W-1], 1'b1, 1'b0, rdy, 1'b0);
            sh = {sh[W-2:0], 1'b0};
        end
    endtask

    // Word monitors: compare every accepted word against the scoreboard.
    always @(negedge clk) begin
        if (!reset && ifm.dout_valid && ifm.dout_ready) begin
            checks++;
            if (qm.size() == 0) begin
                errors++;
                $display("FAIL word_m: got %0h expected none (empty queue)", ifm.dout);
            end else begin
                logic [W-1:0] e;
                e = qm.pop_front();
                if (ifm.dout !== e) begin
                    errors++;
                    $display("FAIL word_m: got %0h expected %0h", ifm.dout, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && ifl.dout_valid && ifl.dout_ready) begin
            checks++;
            if (ql.size() == 0) begin
                errors++;
                $display("FAIL word_l: got %0h expected none (empty queue)", ifl.dout);
            end else begin
                logic [W-1:0] e;
                e = ql.pop_front();
                if (ifl.dout !== e) begin
                    errors++;
                    $display("FAIL word_l: got %0h expected %0h", ifl.dout, e);
                end
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        do_reset(1'b0, 1'b0);

        // Single word F3, continuously ready consumer.
        send_word(8'hF3, 1'b1, 1'b0);
        chk("t1_dout", 32'(ifm.dout), 32'h00F3);
        chk("t1_valid", 32'(ifm.dout_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_valid_pulse", 32'(ifm.dout_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back words from the PISO stream.
        send_word(8'h6D, 1'b1, 1'b0);
        send_word(8'hE7, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun: second word dropped while the first is held.
        send_word(8'hA5, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0);
        chk("t3_hold", 32'(ifm.dout), 32'h00A5);
        chk("t3_ovr", 32'(ifm.overrun), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_clr", 32'(ifm.overrun), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_consume", 32'(ifm.dout_valid), 32'd0);

        // Partial word then sync strobe (with a bit offered) then a clean word.
        for (int i = 0; i < 4; i++) cyc(1'(8'hE7 >> (7 - i)), 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("t4_sync_cnt", 32'(ifm.bit_cnt), 32'd0);
        send_word(8'h5A, 1'b1, 1'b0);
        chk("t4_dout", 32'(ifm.dout), 32'h005A);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset(1'b1, 1'b1);
        chk("t5_rst_dout", 32'(ifm.dout), 32'd0);
        send_word(8'h81, 1'b1, 1'b0);
        chk("t5_dout", 32'(ifm.dout), 32'h0081);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // LSB-first instance: arrival 1,0,0,... gives 01, with and without gaps.
        send_word(8'h80, 1'b1, 1'b0);
        chk("t6_lsb", 32'(ifl.dout), 32'h0001);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(8'h80, 1'b1, 1'b1);
        chk("t6_lsb_gaps", 32'(ifl.dout), 32'h0001);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0)
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                cyc(1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 9) == 0);
        end

        // Drain and confirm every predicted word was seen.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_m", 32'(qm.size()), 32'd0);
        chk("drain_l", 32'(ql.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
